// File: rtl/fir_capture_buffer_pkg.sv
// Shared types and sizing for the FIR capture buffer: capture FSM states and
// default buffer geometry.
package fir_capture_pkg;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_TRIG,
        POST,
        DONE
    } cap_state_t;

endpackage

// File: rtl/fir_capture_buffer_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A same-address read and write in one cycle returns the previous contents.
module capture_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fir_capture_buffer.sv
// Decimating trigger capture of the FIR output stream into a ring buffer,
// with a programmable pre-trigger length and register-side readout.
module fir_capture_buffer #(
    parameter int unsigned DEPTH = fir_capture_pkg::DEPTH,
    parameter int unsigned AW    = fir_capture_pkg::AW,
    parameter int unsigned DEC_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [15:0]  d_in,
    input  logic                in_valid,
    input  logic                arm,
    input  logic                abort,
    input  logic [DEC_W-1:0]    dec_factor,
    input  logic signed [15:0]  trig_level,
    input  logic [AW-1:0]       pre_len,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [15:0]  rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                triggered,
    output logic                done,
    output logic [AW-1:0]       trig_ptr
);

    import fir_capture_pkg::*;

    cap_state_t state, state_nxt;

    logic [DEC_W-1:0]   dec_r;
    logic [DEC_W-1:0]   dec_cnt;
    logic [DEC_W-1:0]   dec_last;
    logic signed [15:0] lvl_r;
    logic signed [15:0] prev;
    logic               prev_ok;
    logic [AW-1:0]      pre_r;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      fill_cnt;
    logic [AW:0]        post_cnt;
    logic [AW:0]        post_target;

    logic capturing;
    logic accept;
    logic start;
    logic trig_hit;
    logic post_last;

    always_comb begin
        capturing   = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
        dec_last    = (dec_r == '0) ? '0 : dec_r - 1'b1;
        accept      = capturing && in_valid && (dec_cnt == dec_last);
        start       = arm && !abort && ((state == IDLE) || (state == DONE));
        trig_hit    = (state == WAIT_TRIG) && accept && prev_ok &&
                      (prev < lvl_r) && (d_in >= lvl_r);
        post_target = (AW+1)'(DEPTH) - {1'b0, pre_r};
        // The trigger sample itself may already complete the record when pre_len is DEPTH-1.
        post_last   = accept &&
                      (((state == POST) && ((post_cnt + 1'b1) == post_target)) ||
                       (trig_hit && (post_target == {{AW{1'b0}}, 1'b1})));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        triggered = 1'b0;

        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start)                 state_nxt = PRE;
                PRE:        if (fill_cnt == pre_r)     state_nxt = WAIT_TRIG;
                WAIT_TRIG:  if (trig_hit)              state_nxt = post_last ? DONE : POST;
                POST:       if (post_last)             state_nxt = DONE;
                default:                               state_nxt = IDLE;
            endcase
        end

        busy      = capturing;
        done      = (state == DONE);
        triggered = (state == POST) || (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_r    <= '0;
            dec_cnt  <= '0;
            lvl_r    <= '0;
            prev     <= '0;
            prev_ok  <= 1'b0;
            pre_r    <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            post_cnt <= '0;
            trig_ptr <= '0;
        end else if (start) begin
            dec_r    <= dec_factor;
            lvl_r    <= trig_level;
            pre_r    <= pre_len;
            dec_cnt  <= '0;
            prev_ok  <= 1'b0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            post_cnt <= '0;
            trig_ptr <= '0;
        end else if (capturing) begin
            if (in_valid) begin
                dec_cnt <= (dec_cnt == dec_last) ? '0 : dec_cnt + 1'b1;
            end
            if (accept) begin
                wr_ptr  <= wr_ptr + 1'b1;
                prev    <= d_in;
                prev_ok <= 1'b1;
                if (state == PRE) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
                if (state == POST) begin
                    post_cnt <= post_cnt + 1'b1;
                end
            end
            if (trig_hit) begin
                trig_ptr <= wr_ptr;
                post_cnt <= {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
        end
    end

    capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (d_in),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Directed bench for fir_capture_buffer: trigger capture, decimation, gapped
// valid, abort, asynchronous reset and readout timing.
module tb_fir_capture_buffer;

    localparam int unsigned AW = 10;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [15:0] d_in;
    logic               in_valid;
    logic               arm;
    logic               abort;
    logic [15:0]        dec_factor;
    logic signed [15:0] trig_level;
    logic [AW-1:0]      pre_len;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic signed [15:0] rd_data;
    logic               rd_valid;
    logic               busy;
    logic               triggered;
    logic               done;
    logic [AW-1:0]      trig_ptr;

    int errors = 0;
    int checks = 0;
    bit seen;

    always #5 clk = ~clk;

    fir_capture_buffer #(
        .DEPTH (1024),
        .AW    (AW),
        .DEC_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_in       (d_in),
        .in_valid   (in_valid),
        .arm        (arm),
        .abort      (abort),
        .dec_factor (dec_factor),
        .trig_level (trig_level),
        .pre_len    (pre_len),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .trig_ptr   (trig_ptr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] addr,
                              input logic signed [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        check(tag, 32'(rd_data), exp);
        check({tag, "_valid_hi"}, 32'(rd_valid), 1);
        rd_en = 1'b0;
        tick();
        check({tag, "_valid_lo"}, 32'(rd_valid), 0);
    endtask

    task automatic arm_capture(input logic [15:0] dec, input logic signed [15:0] lvl,
                               input logic [AW-1:0] pre);
        dec_factor = dec;
        trig_level = lvl;
        pre_len    = pre;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        d_in       = '0;
        in_valid   = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        dec_factor = 16'd1;
        trig_level = '0;
        pre_len    = '0;

        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_triggered", 32'(triggered), 0);
        check("rst_trig_ptr", 32'(trig_ptr), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        reset = 1'b1;
        tick();

        // Basic trigger: ramp from -100, crossing of level 0 lands at address 100.
        arm_capture(16'd1, 16'sd0, 10'd4);
        d_in     = -16'sd100;
        in_valid = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (triggered && !seen) begin
                seen = 1'b1;
                check("t1_trig_sample", 32'(d_in), 0);
                check("t1_trig_ptr_at_trig", 32'(trig_ptr), 100);
            end
            if (done) break;
            d_in = d_in + 16'sd1;
        end
        check("t1_done", 32'(done), 1);
        check("t1_last_sample", 32'(d_in), 1019);
        check("t1_busy", 32'(busy), 0);
        check("t1_triggered", 32'(triggered), 1);
        check("t1_trig_ptr", 32'(trig_ptr), 100);

        for (int i = 0; i < 5; i++) begin
            d_in = d_in + 16'sd1;
            tick();
        end
        in_valid = 1'b0;
        check("t1_done_held", 32'(done), 1);
        read_check("rd_addr100", 10'd100, 0);
        read_check("rd_addr96", 10'd96, -4);
        read_check("rd_addr95", 10'd95, 1019);
        read_check("rd_addr99", 10'd99, -1);

        // Re-arm from DONE, then drop reset asynchronously mid-POST.
        arm_capture(16'd1, 16'sd0, 10'd4);
        check("t5_busy", 32'(busy), 1);
        check("t5_done_cleared", 32'(done), 0);
        check("t5_trig_cleared", 32'(triggered), 0);
        d_in     = -16'sd10;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (triggered) break;
            d_in = d_in + 16'sd1;
        end
        check("t5_triggered", 32'(triggered), 1);
        check("t5_trig_ptr", 32'(trig_ptr), 10);
        for (int i = 0; i < 3; i++) begin
            d_in = d_in + 16'sd1;
            tick();
        end
        rd_en   = 1'b1;
        rd_addr = 10'd10;
        tick();
        check("t5_rd_data", 32'(rd_data), 0);
        check("t5_rd_valid", 32'(rd_valid), 1);
        rd_en = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_triggered", 32'(triggered), 0);
        check("t5_rst_trig_ptr", 32'(trig_ptr), 0);
        check("t5_rst_rd_valid", 32'(rd_valid), 0);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        tick();

        // Decimation by 4; ramp phase puts accepted samples on multiples of 4.
        // A mid-capture arm must be ignored.
        arm_capture(16'd4, -16'sd1000, 10'd0);
        d_in     = -16'sd3;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            arm = (i == 20);
            tick();
            d_in = d_in + 16'sd1;
        end
        arm      = 1'b0;
        in_valid = 1'b0;
        check("t2_busy", 32'(busy), 1);
        check("t2_triggered", 32'(triggered), 0);
        check("t2_done", 32'(done), 0);
        read_check("t2_addr0", 10'd0, 0);
        read_check("t2_addr1", 10'd1, 4);
        read_check("t2_addr2", 10'd2, 8);
        read_check("t2_addr9", 10'd9, 36);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t2_abort_busy", 32'(busy), 0);

        // Gapped valid with decimation by 2: one write per four clocks.
        arm_capture(16'd2, 16'sd30000, 10'd0);
        for (int k = 0; k < 24; k++) begin
            d_in     = 16'(k);
            in_valid = (k % 2 == 0);
            tick();
        end
        in_valid = 1'b0;
        read_check("t3_addr0", 10'd0, 2);
        read_check("t3_addr1", 10'd1, 6);
        read_check("t3_addr5", 10'd5, 22);
        read_check("t3_addr6_untouched", 10'd6, 24);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Abort during capture, then arm+abort together while idle.
        arm_capture(16'd1, 16'sd0, 10'd4);
        d_in     = 16'sd500;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
        end
        check("t4_busy_before", 32'(busy), 1);
        check("t4_trig_before", 32'(triggered), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_busy", 32'(busy), 0);
        check("t4_abort_done", 32'(done), 0);
        check("t4_abort_triggered", 32'(triggered), 0);
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("t4_arm_abort_busy", 32'(busy), 0);
        tick();
        check("t4_arm_abort_idle", 32'(busy), 0);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
